// File: rtl/display_scanner.sv
// display_scanner: time-multiplexes an 8-entry hex digit bank onto a shared
// active-low cathode bus (Salida) and active-low anode bus (AN), with an
// all-off gap before every digit slot so the previous digit never ghosts.
module display_scanner #(
  parameter int SHOW_TICKS  = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Wr_en,
  input  logic [2:0] Wr_addr,
  input  logic [3:0] Wr_data,
  input  logic       Wr_dp,
  input  logic [7:0] Digit_en,
  output logic [7:0] Salida,
  output logic [7:0] AN,
  output logic       Frame_done
);

  localparam int MAX_TICKS = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  // Set by reset so the first edge after release starts frame 0 and pulses Frame_done.
  logic             fresh;

  logic [3:0] digits [8];
  logic [7:0] dps;

  logic [2:0] idx_next;
  logic [7:0] an_cur;
  logic [7:0] seg_cur;
  logic [7:0] an_next;
  logic [7:0] seg_next;

  // Active-low {a..g} pattern for a hex value, with the dp cathode appended in bit 0.
  function automatic logic [7:0] encode(input logic [3:0] value, input logic dp);
    logic [7:0] code;
    case (value)
      4'h0:    code = 8'h03;
      4'h1:    code = 8'h9F;
      4'h2:    code = 8'h25;
      4'h3:    code = 8'h0D;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h49;
      4'h6:    code = 8'h41;
      4'h7:    code = 8'h1F;
      4'h8:    code = 8'h01;
      4'h9:    code = 8'h19;
      4'hA:    code = 8'h11;
      4'hB:    code = 8'hC1;
      4'hC:    code = 8'h63;
      4'hD:    code = 8'h85;
      4'hE:    code = 8'h61;
      default: code = 8'h71;
    endcase
    return {code[7:1], ~dp};
  endfunction

  // Register bank written by the datapath; reset wins over a concurrent write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        digits[i] <= 4'h0;
      end
      dps <= 8'h00;
    end else if (Wr_en) begin
      digits[Wr_addr] <= Wr_data;
      dps[Wr_addr]    <= Wr_dp;
    end
  end

  // Pin values for the current slot and for the following slot, honouring the enable mask.
  always_comb begin
    idx_next = idx + 3'd1;
    an_cur   = 8'hFF;
    seg_cur  = 8'hFF;
    an_next  = 8'hFF;
    seg_next = 8'hFF;
    if (Digit_en[idx]) begin
      an_cur  = ~(8'b1 << idx);
      seg_cur = encode(digits[idx], dps[idx]);
    end
    if (Digit_en[idx_next]) begin
      an_next  = ~(8'b1 << idx_next);
      seg_next = encode(digits[idx_next], dps[idx_next]);
    end
  end

  // Slot sequencer: BLANK gap then SHOW per digit, outputs registered on the entering edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= BLANK;
      idx        <= 3'd0;
      cnt        <= '0;
      fresh      <= 1'b1;
      AN         <= 8'hFF;
      Salida     <= 8'hFF;
      Frame_done <= 1'b0;
    end else begin
      Frame_done <= 1'b0;
      fresh      <= 1'b0;
      if (fresh) begin
        cnt        <= '0;
        Frame_done <= 1'b1;
        if (BLANK_TICKS == 0) begin
          state  <= SHOW;
          AN     <= an_cur;
          Salida <= seg_cur;
        end else begin
          state  <= BLANK;
          AN     <= 8'hFF;
          Salida <= 8'hFF;
        end
      end else begin
        case (state)
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state  <= SHOW;
              cnt    <= '0;
              AN     <= an_cur;
              Salida <= seg_cur;
            end else begin
              cnt    <= cnt + 1'b1;
              AN     <= 8'hFF;
              Salida <= 8'hFF;
            end
          end
          default: begin
            if (cnt == SHOW_LAST) begin
              idx        <= idx_next;
              cnt        <= '0;
              Frame_done <= (idx_next == 3'd0);
              if (BLANK_TICKS == 0) begin
                state  <= SHOW;
                AN     <= an_next;
                Salida <= seg_next;
              end else begin
                state  <= BLANK;
                AN     <= 8'hFF;
                Salida <= 8'hFF;
              end
            end else begin
              cnt    <= cnt + 1'b1;
              AN     <= an_cur;
              Salida <= seg_cur;
            end
          end
        endcase
      end
    end
  end

endmodule
